div_multicycle: RTL and testbench

DIV_MULTICYCLE -- requirements
Module: div_multicycle

---
 rtl/div_multicycle.sv | 161 ++++++++++++++++
 tb/tb_div_multicycle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_multicycle.sv
// Multi-cycle restoring radix-2 divider, signed/unsigned, with optional
// early termination that skips leading-zero dividend bits.
module div_multicycle #(
  parameter int N_WIDTH    = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [N_WIDTH-1:0] i_dividend,
  input  logic [N_WIDTH-1:0] i_divisor,
  input  logic               i_cancel,
  input  logic               i_res_rdy,
  output logic               o_ready,
  output logic               o_done_vld,
  output logic [N_WIDTH-1:0] o_quotient,
  output logic [N_WIDTH-1:0] o_remainder,
  output logic               o_div_by_zero
);

  localparam int CW = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] dq_q, dq_d;
  logic [N_WIDTH-1:0] rem_q, rem_d;
  logic [N_WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic               dvd_neg, dvs_neg;
  logic [N_WIDTH-1:0] dvd_mag, dvs_mag;
  logic [CW-1:0]      lz, k_iter, shamt;
  logic [N_WIDTH:0]   pr, diff;
  logic               qbit;

  function automatic logic [CW-1:0] lzc(input logic [N_WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = N_WIDTH - 1; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

  assign accept  = (state_q == IDLE) && i_start && !i_cancel;
  assign dvd_neg = i_signed & i_dividend[N_WIDTH-1];
  assign dvs_neg = i_signed & i_divisor[N_WIDTH-1];
  assign dvd_mag = dvd_neg ? -i_dividend : i_dividend;
  assign dvs_mag = dvs_neg ? -i_divisor : i_divisor;

  // Iteration count; a zero dividend still takes one iteration.
  always_comb begin
    lz = lzc(dvd_mag);
    if (EARLY_TERM == 0)            k_iter = CW'(N_WIDTH);
    else if (lz == CW'(N_WIDTH))    k_iter = CW'(1);
    else                            k_iter = CW'(N_WIDTH) - lz;
    shamt = CW'(N_WIDTH) - k_iter;
  end

  // One restoring step: dq_q shifts dividend bits out the top and quotient bits in the bottom.
  assign pr   = {rem_q, dq_q[N_WIDTH-1]};
  assign diff = pr - {1'b0, dvs_q};
  assign qbit = ~diff[N_WIDTH];

  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvs_d  = dvs_mag;
          negq_d = dvd_neg ^ dvs_neg;
          negr_d = dvd_neg;
          if (i_divisor == '0) begin
            state_d = DONE;
            dq_d    = '1;
            rem_d   = i_dividend;
            cnt_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dq_d    = dvd_mag << shamt;
            rem_d   = '0;
            cnt_d   = k_iter;
            dbz_d   = 1'b0;
          end
        end
      end
      CALC: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else begin
          dq_d  = {dq_q[N_WIDTH-2:0], qbit};
          rem_d = qbit ? diff[N_WIDTH-1:0] : pr[N_WIDTH-1:0];
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (i_cancel || i_res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dq_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dbz_q   <= dbz_d;
    end
  end

  // Results are sign-corrected on the fly and only visible in DONE.
  always_comb begin
    o_ready       = (state_q == IDLE);
    o_done_vld    = (state_q == DONE);
    o_quotient    = '0;
    o_remainder   = '0;
    o_div_by_zero = 1'b0;
    if (state_q == DONE) begin
      o_quotient    = negq_q ? -dq_q : dq_q;
      o_remainder   = negr_q ? -rem_q : rem_q;
      o_div_by_zero = dbz_q;
    end
  end

endmodule

// File: tb/tb_div_multicycle.sv
// Directed bench for div_multicycle: one instance with fixed iteration count,
// one with early termination, both 32 bits wide.
module tb_div_multicycle;
  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, sgn, cancel, res_rdy;
  logic [N-1:0] dvd, dvs, q, r;
  logic         ready, done, dbz;

  logic         rst_n1, start1, sgn1, cancel1, res_rdy1;
  logic [N-1:0] dvd1, dvs1, q1, r1;
  logic         ready1, done1, dbz1;

  int checks = 0;
  int errors = 0;

  div_multicycle #(.N_WIDTH(N), .EARLY_TERM(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .i_cancel(cancel), .i_res_rdy(res_rdy),
    .o_ready(ready), .o_done_vld(done), .o_quotient(q), .o_remainder(r),
    .o_div_by_zero(dbz)
  );

  div_multicycle #(.N_WIDTH(N), .EARLY_TERM(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n1), .i_start(start1), .i_signed(sgn1),
    .i_dividend(dvd1), .i_divisor(dvs1), .i_cancel(cancel1), .i_res_rdy(res_rdy1),
    .o_ready(ready1), .o_done_vld(done1), .o_quotient(q1), .o_remainder(r1),
    .o_div_by_zero(dbz1)
  );

  // Latency = number of edges from the accept edge to the first edge that sees o_done_vld=1.
  task automatic run_op0(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op1(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    sgn1 = s; dvd1 = a; dvs1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release0();
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
  endtask

  task automatic release1();
    res_rdy1 = 1'b1;
    @(posedge clk); #1;
    res_rdy1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n1 = 1'b0;
    start = 1'b1; start1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got %h exp 0", q); end
    checks++; if (r !== '0) begin errors++; $display("FAIL reset_r got %h exp 0", r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", dbz); end
    checks++; if (ready1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got rdy=%b vld=%b exp 1 0", ready1, done1); end
    start = 1'b0; start1 = 1'b0;
    rst_n = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_fixed();
    int lat;
    run_op0(1'b0, 32'd100, 32'd7, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL u100_7_latency got %0d exp 33", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL u100_7_q got %0d exp 14", q); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL u100_7_r got %0d exp 2", r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL u100_7_dbz got %b exp 0", dbz); end
    release0();
    checks++; if (ready !== 1'b1 || done !== 1'b0 || q !== '0) begin errors++; $display("FAIL u100_7_release got rdy=%b vld=%b q=%h exp 1 0 0", ready, done, q); end
    // Unsigned mode must not treat the MSB as a sign: 0xFFFFFFF9 / 2
    run_op0(1'b0, 32'hFFFF_FFF9, 32'd2, lat);
    checks++; if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin errors++; $display("FAIL u_big_div2 got q=%h r=%h exp 7ffffffc 1", q, r); end
    release0();
  endtask

  task automatic test_signed();
    int lat;
    run_op0(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s_m7_2_q got %h exp fffffffd", q); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL s_m7_2_r got %h exp ffffffff", r); end
    release0();
    run_op0(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL s_min_m1_q got %h exp 80000000", q); end
    checks++; if (r !== 32'h0 || dbz !== 1'b0) begin errors++; $display("FAIL s_min_m1_r got r=%h dbz=%b exp 0 0", r, dbz); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL s_min_m1_latency got %0d exp 33", lat); end
    release0();
    // 7 / -2 -> q=-3, r=+1
    run_op0(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'd1) begin errors++; $display("FAIL s_7_m2 got q=%h r=%h exp fffffffd 1", q, r); end
    release0();
  endtask

  task automatic test_div_by_zero();
    int lat;
    run_op0(1'b0, 32'h1234_5678, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency got %0d exp 1", lat); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_q got %h exp ffffffff", q); end
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL dbz_r got %h exp 12345678", r); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b exp 1", dbz); end
    release0();
    checks++; if (dbz !== 1'b0 || r !== '0) begin errors++; $display("FAIL dbz_cleared got dbz=%b r=%h exp 0 0", dbz, r); end
    run_op0(1'b1, 32'hFFFF_FFF0, 32'h0, lat);
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF0 || dbz !== 1'b1) begin errors++; $display("FAIL dbz_signed got q=%h r=%h dbz=%b exp ffffffff fffffff0 1", q, r, dbz); end
    release0();
  endtask

  task automatic test_early_term();
    int lat;
    run_op1(1'b0, 32'd5, 32'd3, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL et_5_3_latency got %0d exp 4", lat); end
    checks++; if (q1 !== 32'd1 || r1 !== 32'd2) begin errors++; $display("FAIL et_5_3 got q=%0d r=%0d exp 1 2", q1, r1); end
    release1();
    run_op1(1'b0, 32'd0, 32'd9, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL et_zero_latency got %0d exp 2", lat); end
    checks++; if (q1 !== 32'd0 || r1 !== 32'd0) begin errors++; $display("FAIL et_zero got q=%0d r=%0d exp 0 0", q1, r1); end
    release1();
    // |-100| has 7 significant bits: -100 / 7 -> q=-14, r=-2 after 8 edges
    run_op1(1'b1, 32'hFFFF_FF9C, 32'd7, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL et_m100_latency got %0d exp 8", lat); end
    checks++; if (q1 !== 32'hFFFF_FFF2 || r1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL et_m100_7 got q=%h r=%h exp fffffff2 fffffffe", q1, r1); end
    release1();
  endtask

  task automatic test_hold();
    int lat;
    int bad;
    run_op0(1'b0, 32'd1000, 32'd33, lat);
    checks++; if (q !== 32'd30 || r !== 32'd10) begin errors++; $display("FAIL hold_result got q=%0d r=%0d exp 30 10", q, r); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sgn = 1'b0; dvd = 32'd7; dvs = 32'd1; start = 1'b1;
      @(posedge clk); #1;
      if (done !== 1'b1 || ready !== 1'b0 || q !== 32'd30 || r !== 32'd10) bad++;
    end
    start = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_frozen got %0d bad cycles exp 0", bad); end
    release0();
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL hold_exit got rdy=%b vld=%b exp 1 0", ready, done); end
    run_op0(1'b0, 32'd9, 32'd3, lat);
    checks++; if (lat !== 33 || q !== 32'd3 || r !== 32'd0) begin errors++; $display("FAIL hold_next got lat=%0d q=%0d r=%0d exp 33 3 0", lat, q, r); end
    release0();
  endtask

  task automatic test_cancel();
    int saw;
    int lat;
    // Cancel during the fifth CALC cycle
    sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL cancel_calc got rdy=%b vld=%b exp 1 0", ready, done); end
    saw = 0;
    repeat (40) begin @(posedge clk); #1; if (done) saw++; end
    checks++; if (saw !== 0) begin errors++; $display("FAIL cancel_calc_novld got %0d exp 0", saw); end
    // Cancel in DONE discards the result
    run_op0(1'b0, 32'd50, 32'd5, lat);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || q !== '0) begin errors++; $display("FAIL cancel_done got rdy=%b vld=%b q=%h exp 1 0 0", ready, done, q); end
    // Cancel together with start in IDLE blocks the accept
    dvd = 32'd50; dvs = 32'd5; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cancel_idle got rdy=%b exp 1", ready); end
  endtask

  task automatic test_reset_mid_calc();
    int saw;
    sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || q !== '0) begin errors++; $display("FAIL rst_calc got rdy=%b vld=%b q=%h exp 1 0 0", ready, done, q); end
    rst_n = 1'b1; start = 1'b0;
    saw = 0;
    repeat (40) begin @(posedge clk); #1; if (done || !ready) saw++; end
    checks++; if (saw !== 0) begin errors++; $display("FAIL rst_calc_idle got %0d busy cycles exp 0", saw); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; cancel = 1'b0; res_rdy = 1'b0; dvd = '0; dvs = '0;
    rst_n1 = 1'b0; start1 = 1'b0; sgn1 = 1'b0; cancel1 = 1'b0; res_rdy1 = 1'b0; dvd1 = '0; dvs1 = '0;
    @(posedge clk); #1;
    test_reset();
    test_unsigned_fixed();
    test_signed();
    test_div_by_zero();
    test_early_term();
    test_hold();
    test_cancel();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
